// File: rtl/regfile_pkg.sv
// Shared types and defaults for the scoreboarded register file.
package regfile_pkg;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } rf_state_e;

   localparam int XLEN_DEF  = 64;
   localparam int NREGS_DEF = 32;

endpackage

// File: rtl/regfile_sb_rport.sv
// One combinational read port: x0 forcing, write-through bypass, and busy lookup.
module regfile_sb_rport
   import regfile_pkg::*;
#(
   parameter int XLEN  = XLEN_DEF,
   parameter int NREGS = NREGS_DEF,
   parameter int AW    = $clog2(NREGS)
) (
   input  logic             en,
   input  logic [AW-1:0]    addr,
   input  logic             we,
   input  logic [AW-1:0]    wr_addr,
   input  logic [XLEN-1:0]  wr_data,
   input  logic [XLEN-1:0]  regs [NREGS],
   input  logic [NREGS-1:0] sb,
   output logic [XLEN-1:0]  data,
   output logic             busy
);

   // The bypassed value is the one the pending write delivers, so it is never busy.
   always_comb begin
      data = '0;
      busy = 1'b0;
      if (en && (addr != '0)) begin
         if (we && (wr_addr == addr)) begin
            data = wr_data;
         end else begin
            data = regs[addr];
            busy = sb[addr];
         end
      end
   end

endmodule

// File: rtl/regfile_sb.sv
// Register file with N read ports, one write port, bypass, x0 hardwired to zero,
// a pending-write scoreboard and a post-reset initialisation sweep.
module regfile_sb
   import regfile_pkg::*;
#(
   parameter  int XLEN      = XLEN_DEF,
   parameter  int NREGS     = NREGS_DEF,
   parameter  int NRD       = 2,
   parameter  int INIT_MODE = 1,
   localparam int AW        = $clog2(NREGS)
) (
   input  logic                clk,
   input  logic                reset,
   output logic                ready,
   input  logic [NRD*AW-1:0]   rd_addr,
   output logic [NRD*XLEN-1:0] rd_data,
   output logic [NRD-1:0]      rd_busy,
   input  logic                we,
   input  logic [AW-1:0]       wr_addr,
   input  logic [XLEN-1:0]     wr_data,
   input  logic                alloc,
   input  logic [AW-1:0]       alloc_addr
);

   rf_state_e        state;
   logic [AW-1:0]    idx;
   logic [XLEN-1:0]  regs [NREGS];
   logic [NREGS-1:0] sb;
   logic [NREGS-1:0] sb_next;
   logic [XLEN-1:0]  init_val;

   assign init_val = (INIT_MODE != 0) ? XLEN'(idx) : '0;

   // Alloc is applied after the write clear so a same-cycle alloc keeps the bit set.
   always_comb begin
      sb_next = sb;
      if (we && (wr_addr != '0)) begin
         sb_next[wr_addr] = 1'b0;
      end
      if (alloc && (alloc_addr != '0)) begin
         sb_next[alloc_addr] = 1'b1;
      end
      sb_next[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_INIT;
         idx   <= '0;
         sb    <= '0;
         ready <= 1'b0;
      end else begin
         case (state)
            ST_INIT: begin
               idx <= idx + AW'(1);
               if (idx == AW'(NREGS - 1)) begin
                  state <= ST_RUN;
                  ready <= 1'b1;
               end
            end
            ST_RUN: begin
               sb <= sb_next;
            end
            default: begin
               state <= ST_INIT;
               ready <= 1'b0;
            end
         endcase
      end
   end

   // Storage carries no reset; the init sweep gives every entry a defined value.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (state == ST_INIT) begin
            regs[idx] <= init_val;
         end else if (we && (wr_addr != '0)) begin
            regs[wr_addr] <= wr_data;
         end
      end
   end

   for (genvar p = 0; p < NRD; p++) begin : g_rport
      regfile_sb_rport #(
         .XLEN  (XLEN),
         .NREGS (NREGS),
         .AW    (AW)
      ) u_rport (
         .en      (ready),
         .addr    (rd_addr[p*AW +: AW]),
         .we      (we),
         .wr_addr (wr_addr),
         .wr_data (wr_data),
         .regs    (regs),
         .sb      (sb),
         .data    (rd_data[p*XLEN +: XLEN]),
         .busy    (rd_busy[p])
      );
   end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: default 2-port/64-bit instance plus a 4-port/32-bit zero-init instance.
module tb_regfile_sb;

   localparam int XLEN = 64;
   localparam int AW   = 5;
   localparam int X4   = 32;
   localparam int A4   = 4;

   logic            clk;
   logic            reset;
   logic            ready;
   logic [2*AW-1:0] rd_addr;
   logic [2*XLEN-1:0] rd_data;
   logic [1:0]      rd_busy;
   logic            we;
   logic [AW-1:0]   wr_addr;
   logic [XLEN-1:0] wr_data;
   logic            alloc;
   logic [AW-1:0]   alloc_addr;

   logic            ready4;
   logic [4*A4-1:0] rd_addr4;
   logic [4*X4-1:0] rd_data4;
   logic [3:0]      rd_busy4;
   logic            we4;
   logic [A4-1:0]   wr_addr4;
   logic [X4-1:0]   wr_data4;
   logic            alloc4;
   logic [A4-1:0]   alloc_addr4;

   int checks;
   int errors;

   regfile_sb u_dut (
      .clk        (clk),
      .reset      (reset),
      .ready      (ready),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .rd_busy    (rd_busy),
      .we         (we),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .alloc      (alloc),
      .alloc_addr (alloc_addr)
   );

   regfile_sb #(
      .XLEN      (32),
      .NREGS     (16),
      .NRD       (4),
      .INIT_MODE (0)
   ) u_dut4 (
      .clk        (clk),
      .reset      (reset),
      .ready      (ready4),
      .rd_addr    (rd_addr4),
      .rd_data    (rd_data4),
      .rd_busy    (rd_busy4),
      .we         (we4),
      .wr_addr    (wr_addr4),
      .wr_data    (wr_data4),
      .alloc      (alloc4),
      .alloc_addr (alloc_addr4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic            we;
      logic [AW-1:0]   wa;
      logic [XLEN-1:0] wd;
      logic            al;
      logic [AW-1:0]   aa;
      logic [AW-1:0]   r0;
      logic [AW-1:0]   r1;
      logic [XLEN-1:0] e0;
      logic [XLEN-1:0] e1;
      logic [1:0]      eb;
   } vec_t;

   vec_t tbl [21];

   function automatic vec_t mk(input logic w, input int wa, input logic [63:0] wd,
                               input logic a, input int aa, input int r0, input int r1,
                               input logic [63:0] e0, input logic [63:0] e1, input logic [1:0] eb);
      vec_t v;
      v.we = w;  v.wa = AW'(wa); v.wd = wd;
      v.al = a;  v.aa = AW'(aa);
      v.r0 = AW'(r0); v.r1 = AW'(r1);
      v.e0 = e0; v.e1 = e1; v.eb = eb;
      return v;
   endfunction

   // Counts low-ready negedges for both instances over a fixed window starting at reset release.
   task automatic count_init(input int exp_main, input int exp_small);
      int n_main;
      int n_small;
      int leaks;
      n_main  = 0;
      n_small = 0;
      leaks   = 0;
      for (int c = 0; c < 40; c++) begin
         if (!ready) begin
            n_main++;
            if ((rd_data !== '0) || (rd_busy !== '0)) leaks++;
         end else begin
            we    = 1'b0;
            alloc = 1'b0;
         end
         if (!ready4) n_small++;
         @(negedge clk);
      end
      chk("init_cycles_main", 64'(n_main), 64'(exp_main));
      chk("init_cycles_small", 64'(n_small), 64'(exp_small));
      chk("init_outputs_zero", 64'(leaks), 64'd0);
      chk("ready_after_init", 64'(ready), 64'd1);
   endtask

   task automatic read2(input string name, input int a0, input int a1,
                        input logic [63:0] e0, input logic [63:0] e1, input logic [1:0] eb);
      rd_addr = {AW'(a1), AW'(a0)};
      #2;
      chk({name, "_d0"}, rd_data[XLEN-1:0], e0);
      chk({name, "_d1"}, rd_data[2*XLEN-1:XLEN], e1);
      chk({name, "_busy"}, 64'(rd_busy), 64'(eb));
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset = 1'b1;
      rd_addr = '0; we = 1'b0; wr_addr = '0; wr_data = '0; alloc = 1'b0; alloc_addr = '0;
      rd_addr4 = '0; we4 = 1'b0; wr_addr4 = '0; wr_data4 = '0; alloc4 = 1'b0; alloc_addr4 = '0;

      tbl[0]  = mk(0, 0, 64'h0,    0, 0,  5, 31, 64'd5,    64'd31,   2'b00);
      tbl[1]  = mk(0, 0, 64'h0,    0, 0,  3,  0, 64'd3,    64'd0,    2'b00);
      tbl[2]  = mk(1, 7, 64'hDEAD, 0, 0,  7,  7, 64'hDEAD, 64'hDEAD, 2'b00);
      tbl[3]  = mk(0, 0, 64'h0,    0, 0,  7,  6, 64'hDEAD, 64'd6,    2'b00);
      tbl[4]  = mk(0, 0, 64'h0,    1, 9,  9,  0, 64'd9,    64'd0,    2'b00);
      tbl[5]  = mk(0, 0, 64'h0,    0, 0,  9,  9, 64'd9,    64'd9,    2'b11);
      tbl[6]  = mk(1, 9, 64'h55,   0, 0,  9,  8, 64'h55,   64'd8,    2'b00);
      tbl[7]  = mk(0, 0, 64'h0,    0, 0,  9,  9, 64'h55,   64'h55,   2'b00);
      tbl[8]  = mk(0, 0, 64'h0,    1, 12, 12, 1, 64'd12,   64'd1,    2'b00);
      tbl[9]  = mk(1, 12, 64'h1234, 1, 12, 12, 13, 64'h1234, 64'd13,  2'b00);
      tbl[10] = mk(0, 0, 64'h0,    0, 0, 12,  0, 64'h1234, 64'd0,    2'b01);
      tbl[11] = mk(1, 0, 64'hFF,   1, 0,  0,  0, 64'd0,    64'd0,    2'b00);
      tbl[12] = mk(0, 0, 64'h0,    0, 0,  0, 12, 64'd0,    64'h1234, 2'b10);
      tbl[13] = mk(1, 12, 64'h77,  0, 0, 12, 12, 64'h77,   64'h77,   2'b00);
      tbl[14] = mk(0, 0, 64'h0,    0, 0, 12, 31, 64'h77,   64'd31,   2'b00);
      tbl[15] = mk(0, 0, 64'h0,    1, 20, 20, 21, 64'd20,  64'd21,   2'b00);
      tbl[16] = mk(0, 0, 64'h0,    1, 20, 20, 20, 64'd20,  64'd20,   2'b11);
      tbl[17] = mk(1, 20, 64'h1,   0, 0, 21, 20, 64'd21,   64'd1,    2'b00);
      tbl[18] = mk(0, 0, 64'h0,    0, 0, 20,  0, 64'd1,    64'd0,    2'b00);
      tbl[19] = mk(1, 30, 64'hABC, 0, 0, 30, 30, 64'hABC,  64'hABC,  2'b00);
      tbl[20] = mk(0, 0, 64'h0,    0, 0, 30, 29, 64'hABC,  64'd29,   2'b00);

      // Reset and first init sweep; writes/allocs driven during INIT must be ignored.
      @(negedge clk);
      chk("reset_ready", 64'(ready), 64'd0);
      chk("reset_ready4", 64'(ready4), 64'd0);
      reset = 1'b0;
      we = 1'b1; wr_addr = 5'd3; wr_data = 64'hAAAA;
      alloc = 1'b1; alloc_addr = 5'd3;
      rd_addr = {5'd3, 5'd5};
      #2;
      chk("init_rd_data", rd_data[XLEN-1:0], 64'd0);
      chk("init_rd_busy", 64'(rd_busy), 64'd0);
      @(negedge clk);
      count_init(31, 15);

      for (int i = 0; i < 21; i++) begin
         we = tbl[i].we; wr_addr = tbl[i].wa; wr_data = tbl[i].wd;
         alloc = tbl[i].al; alloc_addr = tbl[i].aa;
         rd_addr = {tbl[i].r1, tbl[i].r0};
         #2;
         chk($sformatf("vec%0d_d0", i), rd_data[XLEN-1:0], tbl[i].e0);
         chk($sformatf("vec%0d_d1", i), rd_data[2*XLEN-1:XLEN], tbl[i].e1);
         chk($sformatf("vec%0d_busy", i), 64'(rd_busy), 64'(tbl[i].eb));
         @(negedge clk);
      end
      we = 1'b0; alloc = 1'b0;

      // Mark x15 busy, then reset in the middle of the next init sweep.
      alloc = 1'b1; alloc_addr = 5'd15;
      @(negedge clk);
      alloc = 1'b0;
      read2("busy15", 15, 0, 64'd15, 64'd0, 2'b01);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      chk("mid_init_ready", 64'(ready), 64'd0);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      count_init(32, 16);
      read2("reinit_a", 15, 7, 64'd15, 64'd7, 2'b00);
      read2("reinit_b", 9, 12, 64'd9, 64'd12, 2'b00);

      // Four-port zero-init instance.
      rd_addr4 = {4'd15, 4'd11, 4'd7, 4'd3};
      #2;
      for (int p = 0; p < 4; p++) begin
         chk($sformatf("small_init_d%0d", p), 64'(rd_data4[p*X4 +: X4]), 64'd0);
      end
      chk("small_init_busy", 64'(rd_busy4), 64'd0);
      @(negedge clk);
      we4 = 1'b1; wr_addr4 = 4'd5; wr_data4 = 32'hCAFEF00D;
      alloc4 = 1'b1; alloc_addr4 = 4'd11;
      rd_addr4 = {4'd0, 4'd2, 4'd11, 4'd5};
      #2;
      chk("small_bypass_d0", 64'(rd_data4[X4-1:0]), 64'hCAFEF00D);
      chk("small_bypass_busy", 64'(rd_busy4), 64'd0);
      @(negedge clk);
      we4 = 1'b0; alloc4 = 1'b0;
      #2;
      chk("small_d0", 64'(rd_data4[0*X4 +: X4]), 64'hCAFEF00D);
      chk("small_d1", 64'(rd_data4[1*X4 +: X4]), 64'd0);
      chk("small_d2", 64'(rd_data4[2*X4 +: X4]), 64'd0);
      chk("small_d3", 64'(rd_data4[3*X4 +: X4]), 64'd0);
      chk("small_busy", 64'(rd_busy4), 64'b0010);
      @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule
